wb_spi_master: RTL and testbench

Wishbone slave on interconnect port S3 (0x0000_3000–0x0000_3FFF). Converts register accesses into byte-wide SPI master transfers to the external secure-memory device.
Provides a programmable SCLK divider, CPOL/CPHA modes and a software-driven chip select. Single clock domain, shared with the interconnect.

---
 rtl/wb_spi_master_if.sv | 21 ++
 rtl/wb_spi_master.sv | 227 ++++++++++++++++++++++
 tb/tb_wb_spi_master.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_spi_master_if.sv
// rtl/wb_spi_master_if.sv - Wishbone slave port bundle for the SPI master
interface wb_spi_master_if;
    logic [31:0] wb_dat_i;
    logic [10:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_spi_master.sv
// rtl/wb_spi_master.sv - Wishbone register slave driving byte-wide SPI master transfers
module wb_spi_master #(
    parameter logic [7:0] DIV_RST = 8'd4,
    parameter logic       CS_RST  = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_n,
    wb_spi_master_if.slave  wb,
    output logic            spi_sclk_o,
    output logic            spi_mosi_o,
    input  logic            spi_miso_i,
    output logic            spi_cs_n_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_ack;
    logic [31:0] r_dat_o;

    logic        r_en;
    logic        r_cpol;
    logic        r_cpha;
    logic        r_cs_n;
    logic [7:0]  r_clk_div;

    logic        r_tx_ovr;
    logic        r_rx_valid;
    logic [7:0]  r_rxdata;

    // transfer-time copies so CTRL edits during busy leave the current byte alone
    logic [7:0]  r_div_l;
    logic        r_cpol_l;
    logic        r_cpha_l;

    logic [7:0]  r_cnt;
    logic [3:0]  r_tgl;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic        r_sclk;
    logic        r_mosi;

    logic        w_req;
    logic [1:0]  w_adr;
    logic        w_wr;
    logic        w_rd;
    logic        w_busy;
    logic        w_ctrl_wr;
    logic        w_st_wr;
    logic        w_tx_wr;
    logic        w_rx_rd;
    logic        w_accept;
    logic        w_tc;
    logic        w_last;
    logic        w_lead;
    logic        w_shift_edge;
    logic [31:0] w_rd_data;
    logic        w_unused;

    assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
    assign w_adr     = wb.wb_adr_i[3:2];
    assign w_wr      = w_req & wb.wb_we_i;
    assign w_rd      = w_req & ~wb.wb_we_i;
    assign w_busy    = (r_state != ST_IDLE);
    assign w_ctrl_wr = w_wr & (w_adr == 2'd0);
    assign w_st_wr   = w_wr & (w_adr == 2'd1);
    assign w_tx_wr   = w_wr & (w_adr == 2'd2);
    assign w_rx_rd   = w_rd & (w_adr == 2'd3);
    assign w_accept  = w_tx_wr & r_en & ~w_busy & wb.wb_sel_i[0];

    assign w_tc      = (r_cnt == r_div_l);
    assign w_last    = w_tc & (r_tgl == 4'd15);
    // even-numbered toggles (0-based) move SCLK away from its idle level
    assign w_lead    = ~r_tgl[0];
    assign w_shift_edge = (w_lead == r_cpha_l);

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat_o;
    assign spi_sclk_o  = r_sclk;
    assign spi_mosi_o  = r_mosi;
    assign spi_cs_n_o  = r_cs_n;

    assign w_unused = ^{wb.wb_dat_i[31:16], wb.wb_adr_i[10:4], wb.wb_adr_i[1:0],
                        wb.wb_sel_i[3:2]};

    always_comb begin
        w_rd_data = 32'd0;
        case (w_adr)
            2'd0:    w_rd_data = {16'd0, r_clk_div, 4'd0, r_cs_n, r_cpha, r_cpol, r_en};
            2'd1:    w_rd_data = {29'd0, r_tx_ovr, r_rx_valid, w_busy};
            2'd3:    w_rd_data = {24'd0, r_rxdata};
            default: w_rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!r_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= 1'b0;
            r_dat_o    <= 32'd0;
            r_en       <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_cs_n     <= CS_RST;
            r_clk_div  <= DIV_RST;
            r_tx_ovr   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rxdata   <= 8'd0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat_o <= wb.wb_we_i ? 32'd0 : w_rd_data;
            end

            if (w_ctrl_wr && wb.wb_sel_i[0]) begin
                r_en   <= wb.wb_dat_i[0];
                r_cpol <= wb.wb_dat_i[1];
                r_cpha <= wb.wb_dat_i[2];
                r_cs_n <= wb.wb_dat_i[3];
            end
            if (w_ctrl_wr && wb.wb_sel_i[1]) begin
                r_clk_div <= wb.wb_dat_i[15:8];
            end

            if (w_tx_wr && w_busy) begin
                r_tx_ovr <= 1'b1;
            end else if (w_st_wr && wb.wb_sel_i[0] && wb.wb_dat_i[2]) begin
                r_tx_ovr <= 1'b0;
            end

            // a completing byte beats a concurrent RXDATA read
            if (r_state == ST_DONE) begin
                r_rx_valid <= 1'b1;
                r_rxdata   <= r_rx;
            end else if (w_rx_rd) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_div_l  <= 8'd0;
            r_cpol_l <= 1'b0;
            r_cpha_l <= 1'b0;
            r_cnt    <= 8'd0;
            r_tgl    <= 4'd0;
            r_tx     <= 8'd0;
            r_rx     <= 8'd0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_sclk <= r_cpol;
                    r_cnt  <= 8'd0;
                    if (w_accept) begin
                        r_div_l  <= r_clk_div;
                        r_cpol_l <= r_cpol;
                        r_cpha_l <= r_cpha;
                        r_tx     <= wb.wb_dat_i[7:0];
                        r_tgl    <= 4'd0;
                        if (!r_cpha) begin
                            r_mosi <= wb.wb_dat_i[7];
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!r_en) begin
                        r_sclk <= r_cpol_l;
                        r_mosi <= 1'b0;
                        r_cnt  <= 8'd0;
                    end else if (w_tc) begin
                        r_cnt  <= 8'd0;
                        r_sclk <= ~r_sclk;
                        r_tgl  <= r_tgl + 4'd1;
                        if (w_shift_edge) begin
                            r_mosi <= r_cpha_l ? r_tx[7] : r_tx[6];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end else begin
                            r_rx <= {r_rx[6:0], spi_miso_i};
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_spi_master.sv
// tb/tb_wb_spi_master.sv - self-checking bench for wb_spi_master
module tb_wb_spi_master;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_spi_master_if bus ();

    logic sclk, mosi, cs_n, miso;
    logic loop_en = 1'b1;
    logic [7:0] drv_byte = 8'd0;
    logic miso_drv = 1'b0;
    assign miso = loop_en ? mosi : miso_drv;

    wb_spi_master dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .wb         (bus),
        .spi_sclk_o (sclk),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso),
        .spi_cs_n_o (cs_n)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    logic [7:0] q_mosi[$];
    logic [7:0] q_rx[$];

    logic mon_on = 1'b0;
    logic idle_pol = 1'b0;
    logic prev_sclk = 1'b0;
    logic prev_busy = 1'b0;
    int cyc_cnt = 0, last_lead = 0, lead_cnt = 0, tgl_cnt = 0, half_exp = 1;
    int busy_cnt = 0, busy_len = 0;
    logic [7:0] mosi_sh = 8'd0;

    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        if (dut.w_busy && !prev_busy) busy_cnt = 1;
        else if (dut.w_busy) busy_cnt++;
        if (!dut.w_busy && prev_busy) busy_len = busy_cnt;
        prev_busy = dut.w_busy;
        if (mon_on && rst_n && sclk != prev_sclk) begin
            tgl_cnt++;
            if (sclk != idle_pol && lead_cnt < 8) begin
                if (lead_cnt > 0) check("sclk_period", cyc_cnt - last_lead, 2 * half_exp);
                last_lead = cyc_cnt;
                if (!loop_en) miso_drv = drv_byte[3'(7 - lead_cnt)];
                mosi_sh = {mosi_sh[6:0], mosi};
                lead_cnt++;
                if (lead_cnt == 8) begin
                    if (q_mosi.size() > 0) check("mosi_byte", {24'd0, mosi_sh}, {24'd0, q_mosi.pop_front()});
                    else check("mosi_unexpected", q_mosi.size(), 1);
                end
            end
        end
        prev_sclk = sclk;
    end

    task automatic wb_acc(input logic [1:0] r, input logic we, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] q);
        logic got;
        @(posedge clk); #1;
        bus.wb_adr_i = {7'd0, r, 2'b00};
        bus.wb_we_i  = we;
        bus.wb_dat_i = d;
        bus.wb_sel_i = s;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o) got = 1'b1;
        end
        q = bus.wb_dat_o;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        if (!got) check("wb_ack_timeout", {31'd0, got}, 1);
    endtask

    task automatic wb_wr(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        wb_acc(r, 1'b1, d, s, q);
    endtask

    task automatic wb_rd(input logic [1:0] r, output logic [31:0] q);
        wb_acc(r, 1'b0, 32'd0, 4'hF, q);
    endtask

    task automatic wait_idle();
        logic [31:0] st;
        int n;
        st = 32'd1;
        n = 0;
        while (st[0] && n < 400) begin
            wb_rd(2'd1, st);
            n++;
        end
        if (st[0]) check("busy_timeout", st[0], 0);
    endtask

    task automatic run_xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                            input logic [7:0] div, input logic loop, input logic [7:0] drv,
                            input logic [7:0] exp_rx);
        mon_on   = 1'b0;
        loop_en  = loop;
        drv_byte = drv;
        miso_drv = 1'b0;
        idle_pol = cpol;
        half_exp = int'(div) + 1;
        wb_wr(2'd0, {16'd0, div, 4'b0000, 1'b0, cpha, cpol, 1'b1}, 4'h3);
        repeat (2) @(posedge clk);
        #1;
        lead_cnt = 0;
        tgl_cnt  = 0;
        mosi_sh  = 8'd0;
        mon_on   = 1'b1;
        q_mosi.push_back(tx);
        q_rx.push_back(exp_rx);
        wb_wr(2'd2, {24'd0, tx}, 4'hF);
    endtask

    task automatic finish_xfer(input logic [7:0] div, input string tag);
        logic [31:0] q;
        wait_idle();
        check({tag, "_busy_len"}, busy_len, 16 * (int'(div) + 1) + 1);
        check({tag, "_bits"}, lead_cnt, 8);
        wb_rd(2'd1, q);
        check({tag, "_rx_valid_set"}, {31'd0, q[1]}, 1);
        wb_rd(2'd3, q);
        check({tag, "_rxdata"}, q, {24'd0, q_rx.pop_front()});
        wb_rd(2'd1, q);
        check({tag, "_rx_valid_clr"}, {31'd0, q[1]}, 0);
    endtask

    task automatic wait_toggles(input int n);
        int k;
        k = 0;
        while (tgl_cnt < n && k < 300) begin
            @(posedge clk); #2;
            k++;
        end
        if (tgl_cnt < n) check("toggle_timeout", tgl_cnt, n);
    endtask

    typedef struct {
        logic [1:0]  r;
        logic        we;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q;
        vecs[0]  = '{2'd0, 1'b0, 32'd0,         4'hF, 32'h0000_0408};
        vecs[1]  = '{2'd1, 1'b0, 32'd0,         4'hF, 32'h0000_0000};
        vecs[2]  = '{2'd2, 1'b0, 32'd0,         4'hF, 32'h0000_0000};
        vecs[3]  = '{2'd3, 1'b0, 32'd0,         4'hF, 32'h0000_0000};
        vecs[4]  = '{2'd0, 1'b1, 32'h0000_FF0F, 4'h2, 32'h0};
        vecs[5]  = '{2'd0, 1'b0, 32'd0,         4'hF, 32'h0000_FF08};
        vecs[6]  = '{2'd0, 1'b1, 32'hFFFF_FF0E, 4'h1, 32'h0};
        vecs[7]  = '{2'd0, 1'b0, 32'd0,         4'hF, 32'h0000_FF0E};
        vecs[8]  = '{2'd2, 1'b1, 32'h0000_00A5, 4'hF, 32'h0};
        vecs[9]  = '{2'd1, 1'b0, 32'd0,         4'hF, 32'h0000_0000};
        vecs[10] = '{2'd0, 1'b1, 32'h0000_0408, 4'h3, 32'h0};
        vecs[11] = '{2'd0, 1'b0, 32'd0,         4'hF, 32'h0000_0408};

        bus.wb_dat_i = 32'd0;
        bus.wb_adr_i = 11'd0;
        bus.wb_sel_i = 4'd0;
        bus.wb_we_i  = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", {31'd0, sclk}, 0);
        check("rst_cs_n", {31'd0, cs_n}, 1);
        check("rst_ack",  {31'd0, bus.wb_ack_o}, 0);
        check("rst_dat",  bus.wb_dat_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            wb_acc(vecs[i].r, vecs[i].we, vecs[i].d, vecs[i].s, q);
            if (!vecs[i].we) check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        run_xfer(8'hA5, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 8'hA5);
        finish_xfer(8'd1, "mode0");

        run_xfer(8'h3C, 1'b1, 1'b1, 8'd0, 1'b0, 8'hC3, 8'hC3);
        finish_xfer(8'd0, "mode3");
        check("mode3_idle_sclk", {31'd0, sclk}, 1);

        run_xfer(8'h5A, 1'b0, 1'b0, 8'd3, 1'b1, 8'h00, 8'h5A);
        wb_wr(2'd2, 32'h11, 4'hF);
        wb_rd(2'd1, q);
        check("ovr_status", q, 32'h5);
        finish_xfer(8'd3, "ovr");
        wb_rd(2'd1, q);
        check("ovr_sticky", q, 32'h4);
        wb_wr(2'd1, 32'h4, 4'h1);
        wb_rd(2'd1, q);
        check("ovr_w1c", q, 32'h0);

        run_xfer(8'h96, 1'b0, 1'b0, 8'd2, 1'b1, 8'h00, 8'h96);
        wait_toggles(5);
        wb_wr(2'd0, 32'h0000_0200, 4'h3);
        @(posedge clk); #1;
        check("abort_sclk", {31'd0, sclk}, 0);
        check("abort_mosi", {31'd0, mosi}, 0);
        q_mosi.delete();
        q_rx.delete();
        wb_rd(2'd1, q);
        check("abort_status", q, 32'h0);
        wb_rd(2'd3, q);
        check("abort_rxdata", q, 32'h5A);

        run_xfer(8'h3C, 1'b1, 1'b1, 8'd3, 1'b1, 8'h00, 8'h3C);
        wait_toggles(2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_sclk", {31'd0, sclk}, 0);
        check("arst_mosi", {31'd0, mosi}, 0);
        check("arst_cs_n", {31'd0, cs_n}, 1);
        check("arst_ack",  {31'd0, bus.wb_ack_o}, 0);
        check("arst_dat",  bus.wb_dat_o, 0);
        #10;
        rst_n = 1'b1;
        mon_on = 1'b0;
        q_mosi.delete();
        q_rx.delete();
        wb_rd(2'd0, q);
        check("arst_ctrl", q, 32'h0000_0408);
        wb_rd(2'd1, q);
        check("arst_status", q, 32'h0);

        run_xfer(8'hFF, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00, 8'hFF);
        finish_xfer(8'd1, "post_rst");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
